// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM (lw, sw, R/I ALU, beq, jal) with a wait-stated memory handshake.
// Optional ILLEGAL_TRAP_EN: unknown opcodes lock the FSM in a trap state and raise illegal.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       bus_err,
`ifdef ILLEGAL_TRAP_EN
  output logic       illegal,
`endif
  output logic [3:0] state_o
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpSw   = 7'b0100011;
  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpBeq  = 7'b1100011;
  localparam logic [6:0] OpJal  = 7'b1101111;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10,
    StTrap     = 4'd11
  } state_e;

  state_e          stateQ, stateD;
  logic [CntW-1:0] waitCntQ, waitCntD;
  logic            busErrQ, busErrD;
  logic            memReqRaw;
  logic [2:0]      aluDec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateQ   <= StFetch;
      waitCntQ <= '0;
      busErrQ  <= 1'b0;
    end else begin
      stateQ   <= stateD;
      waitCntQ <= waitCntD;
      busErrQ  <= busErrD;
    end
  end

  // Subtract only for R-type with funct7b5; I-type addi ignores instr[30].
  always_comb begin
    aluDec = 3'b000;
    case (funct3)
      3'b000:  aluDec = (stateQ == StExecR && funct7b5) ? 3'b001 : 3'b000;
      3'b010:  aluDec = 3'b101;
      3'b110:  aluDec = 3'b011;
      3'b111:  aluDec = 3'b010;
      default: aluDec = 3'b000;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OpSw:    ImmSrc = 2'b01;
      OpBeq:   ImmSrc = 2'b10;
      OpJal:   ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    stateD     = stateQ;
    waitCntD   = '0;
    busErrD    = busErrQ;
    memReqRaw  = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    case (stateQ)
      StFetch: begin
        memReqRaw = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) stateD = StDecode;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OpLw, OpSw: stateD = StMemAdr;
          OpR:        stateD = StExecR;
          OpI:        stateD = StExecI;
          OpBeq:      stateD = StBeq;
          OpJal:      stateD = StJal;
`ifdef ILLEGAL_TRAP_EN
          default:    stateD = StTrap;
`else
          default:    stateD = StFetch;
`endif
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        stateD  = (op == OpSw) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        memReqRaw = 1'b1;
        AdrSrc    = 1'b1;
        if (mem_ready) stateD = StMemWb;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        stateD    = StFetch;
      end
      StMemWrite: begin
        memReqRaw = 1'b1;
        MemWrite  = 1'b1;
        AdrSrc    = 1'b1;
        if (mem_ready) stateD = StFetch;
      end
      StExecR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = aluDec;
        stateD     = StAluWb;
      end
      StExecI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = aluDec;
        stateD     = StAluWb;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        stateD   = StFetch;
      end
      StBeq: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        PCWrite    = Zero;
        stateD     = StFetch;
      end
      StJal: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        stateD  = StAluWb;
      end
      StTrap:  stateD = StTrap;
      default: stateD = StFetch;
    endcase

    // Watchdog: a mem_ready on the limit cycle still completes normally.
    if (memReqRaw && !mem_ready) begin
      if (waitCntQ == CntMax) begin
        stateD  = StFetch;
        busErrD = 1'b1;
      end else begin
        waitCntD = waitCntQ + 1'b1;
      end
    end
  end

  // Keep the memory from seeing a request while reset is held.
  assign mem_req = memReqRaw & reset_n;
  assign bus_err = busErrQ;
  assign state_o = stateQ;
`ifdef ILLEGAL_TRAP_EN
  assign illegal = (stateQ == StTrap);
`endif

endmodule
